// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES key schedule.
//   PC1_TBL   : permuted choice 1 (64-bit key -> C0/D0), FIPS 46-3 numbering
//   PC2_TBL   : permuted choice 2 (C/D 56 bits -> 48-bit subkey)
//   SHIFT_TBL : per-round left rotation amount, indexed by round 1..16
//   ROUNDS    : number of subkeys per key
//   ks_state_e: key-schedule FSM states
//   rotl28/rotr28: 28-bit rotations by 1 or 2 toward/away from bit 1
package des_pkg;

  localparam int unsigned ROUNDS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  localparam int unsigned PC1_TBL [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT_TBL [1:16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Left rotation moves bits toward index 1 (the MSB in FIPS numbering).
  function automatic logic [1:28] rotl28(input logic [1:28] x, input int unsigned s);
    return (s == 2) ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr28(input logic [1:28] x, input int unsigned s);
    return (s == 2) ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational DES permuted choice 2.
//   cd_i [1:56] : concatenated C (bits 1..28) and D (bits 29..56)
//   k_o  [1:48] : 48-bit round subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd_i,
  output logic [1:48] k_o
);

  always_comb begin
    k_o = '0;
    for (int unsigned i = 1; i <= 48; i++) begin
      k_o[i] = cd_i[PC2_TBL[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES subkey generator, one subkey per enabled cycle.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (priority over enable/i_valid)
//   enable   : global advance; 0 freezes every register
//   i_valid  : load request for key (accepted only when idle and not busy)
//   key      : [1:64] DES key, parity bits 8,16,..,64 ignored
//   decrypt  : latched with key; 1 selects K16..K1 order
//   o_valid  : Kn holds a valid subkey
//   Kn       : [1:48] subkey (PC-2 output)
//   round    : round index of Kn, 1..16 (5 bits wide so 16 is representable)
//   o_last   : Kn is the final subkey of the sequence
//   busy     : sequence in progress, i_valid ignored
// Optional feature macro: DES_KS_DECRYPT_EN enables the decrypt input and
// reverse (right-rotating) order; without it decrypt is ignored.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        i_valid,
  input  logic [1:64] key,
  input  logic        decrypt,
  output logic        o_valid,
  output logic [1:48] Kn,
  output logic [4:0]  round,
  output logic        o_last,
  output logic        busy
);

  ks_state_e   state_q;
  logic [1:28] c_q, d_q;
  logic [3:0]  step_q;
  logic        o_valid_q, o_last_q, busy_q;
  logic [1:48] kn_q;
  logic [4:0]  round_q;
`ifdef DES_KS_DECRYPT_EN
  logic        dec_q;
`endif

  logic [1:28] c_pc1, d_pc1;
  logic [1:28] c_d, d_d;
  logic [4:0]  round_d;
  logic [1:56] pc2_in;
  logic [1:48] kn_d;
  logic        last_d;
  logic        accept;

  logic unused_parity;
  assign unused_parity = ^{key[8], key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};
`ifndef DES_KS_DECRYPT_EN
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  always_comb begin
    c_pc1 = '0;
    d_pc1 = '0;
    for (int unsigned i = 1; i <= 28; i++) begin
      c_pc1[i] = key[PC1_TBL[i]];
      d_pc1[i] = key[PC1_TBL[i + 28]];
    end
  end

  // Encrypt rotates before PC-2 and stores the rotated halves. Decrypt feeds
  // the current halves to PC-2 (C0D0 == C16D16) and then undoes that round's
  // rotation, so both directions share one PC-2 instance.
  always_comb begin
    last_d  = (step_q == 4'(ROUNDS - 1));
    round_d = {1'b0, step_q} + 5'd1;
    c_d     = rotl28(c_q, SHIFT_TBL[round_d]);
    d_d     = rotl28(d_q, SHIFT_TBL[round_d]);
    pc2_in  = {c_d, d_d};
`ifdef DES_KS_DECRYPT_EN
    if (dec_q) begin
      round_d = 5'(ROUNDS) - {1'b0, step_q};
      pc2_in  = {c_q, d_q};
      c_d     = rotr28(c_q, SHIFT_TBL[round_d]);
      d_d     = rotr28(d_q, SHIFT_TBL[round_d]);
    end
`endif
  end

  des_pc2 u_pc2 (
    .cd_i (pc2_in),
    .k_o  (kn_d)
  );

  // busy stays high through the o_last cycle and drops one cycle later, so a
  // key offered alongside o_last is ignored.
  assign accept = i_valid && !busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      step_q    <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      kn_q      <= '0;
      round_q   <= '0;
`ifdef DES_KS_DECRYPT_EN
      dec_q     <= 1'b0;
`endif
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          o_valid_q <= 1'b0;
          o_last_q  <= 1'b0;
          busy_q    <= 1'b0;
          if (accept) begin
            c_q     <= c_pc1;
            d_q     <= d_pc1;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef DES_KS_DECRYPT_EN
            dec_q   <= decrypt;
`endif
          end
        end
        RUN: begin
          o_valid_q <= 1'b1;
          kn_q      <= kn_d;
          round_q   <= round_d;
          o_last_q  <= last_d;
          c_q       <= c_d;
          d_q       <= d_d;
          step_q    <= step_q + 4'd1;
          if (last_d) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid = o_valid_q;
  assign Kn      = kn_q;
  assign round   = round_q;
  assign o_last  = o_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        i_valid;
  logic [1:64] key;
  logic        decrypt;
  logic        o_valid;
  logic [1:48] Kn;
  logic [4:0]  round;
  logic        o_last;
  logic        busy;

  int total;
  int bad;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
`ifdef DES_KS_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic [47:0] exp_k [1:16];

  des_key_schedule dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .i_valid (i_valid),
    .key     (key),
    .decrypt (decrypt),
    .o_valid (o_valid),
    .Kn      (Kn),
    .round   (round),
    .o_last  (o_last),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive a one-cycle load request; returns #1 after the accepting edge.
  task automatic accept_key(input logic [63:0] k, input logic d);
    i_valid = 1'b1;
    key     = k;
    decrypt = d;
    @(posedge clk); #1;
    i_valid = 1'b0;
    decrypt = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; i_valid = 1'b0; key = '0; decrypt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_valid, o_last, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got v=%b l=%b b=%b want 0 0 0", o_valid, o_last, busy);
    end
    total++;
    if (Kn !== 48'h0 || round !== 5'd0) begin
      bad++;
      $display("FAIL reset_data: got k=%h r=%0d want k=0 r=0", Kn, round);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got v=%b b=%b want 0 0", o_valid, busy);
    end
  endtask

  task automatic test_encrypt;
    accept_key(KEY_A, 1'b0);
    total++;
    if (busy !== 1'b1 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL enc_accept: got b=%b v=%b want b=1 v=0", busy, o_valid);
    end
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      total++;
      if ({o_valid, round, Kn, o_last, busy} !== {1'b1, 5'(n), exp_k[n], (n == 16), 1'b1}) begin
        bad++;
        $display("FAIL enc_k%0d: got v=%b r=%0d k=%h l=%b b=%b want v=1 r=%0d k=%h l=%b b=1",
                 n, o_valid, round, Kn, o_last, busy, n, exp_k[n], (n == 16));
      end
    end
    @(posedge clk); #1;
    total++;
    if ({o_valid, o_last, busy, round, Kn} !== {3'b000, 5'd16, exp_k[16]}) begin
      bad++;
      $display("FAIL enc_idle_hold: got v=%b l=%b b=%b r=%0d k=%h want 0 0 0 r=16 k=%h",
               o_valid, o_last, busy, round, Kn, exp_k[16]);
    end
  endtask

  task automatic test_decrypt;
    int r;
    accept_key(KEY_A, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      r = DEC_EN ? 17 - n : n;
      @(posedge clk); #1;
      total++;
      if ({o_valid, round, Kn, o_last} !== {1'b1, 5'(r), exp_k[r], (n == 16)}) begin
        bad++;
        $display("FAIL dec_step%0d: got v=%b r=%0d k=%h l=%b want v=1 r=%0d k=%h l=%b",
                 n, o_valid, round, Kn, o_last, r, exp_k[r], (n == 16));
      end
    end
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dec_end: got v=%b b=%b want 0 0", o_valid, busy);
    end
  endtask

  task automatic test_enable_toggle;
    int windows;
    windows = 0;
    accept_key(KEY_A, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      enable = 1'b0;
      @(posedge clk); #1;
      if (n == 1) begin
        total++;
        if (o_valid !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL en_hold_first: got v=%b b=%b want v=0 b=1", o_valid, busy);
        end
      end else begin
        total++;
        if ({o_valid, round, Kn} !== {1'b1, 5'(n - 1), exp_k[n - 1]}) begin
          bad++;
          $display("FAIL en_hold%0d: got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                   n, o_valid, round, Kn, n - 1, exp_k[n - 1]);
        end
      end
      enable = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({o_valid, round, Kn, o_last} !== {1'b1, 5'(n), exp_k[n], (n == 16)}) begin
        bad++;
        $display("FAIL en_step%0d: got v=%b r=%0d k=%h l=%b want v=1 r=%0d k=%h l=%b",
                 n, o_valid, round, Kn, o_last, n, exp_k[n], (n == 16));
      end else begin
        windows++;
      end
    end
    enable = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({o_valid, o_last, busy, round} !== {3'b111, 5'd16}) begin
      bad++;
      $display("FAIL en_hold_last: got v=%b l=%b b=%b r=%0d want 1 1 1 r=16",
               o_valid, o_last, busy, round);
    end
    enable = 1'b1;
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || windows != 16) begin
      bad++;
      $display("FAIL en_end: got v=%b b=%b windows=%0d want 0 0 16", o_valid, busy, windows);
    end
  endtask

  task automatic test_busy_ignore;
    accept_key(KEY_A, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      if (n == 4) begin
        i_valid = 1'b1;
        key     = 64'h0;
      end
      if (n == 6) i_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({o_valid, round, Kn, o_last} !== {1'b1, 5'(n), exp_k[n], (n == 16)}) begin
        bad++;
        $display("FAIL ign_k%0d: got v=%b r=%0d k=%h l=%b want v=1 r=%0d k=%h l=%b",
                 n, o_valid, round, Kn, o_last, n, exp_k[n], (n == 16));
      end
    end
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_no_queue: got v=%b b=%b want 0 0", o_valid, busy);
    end
    accept_key(64'h0, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      total++;
      if ({o_valid, round, Kn, o_last} !== {1'b1, 5'(n), 48'h0, (n == 16)}) begin
        bad++;
        $display("FAIL zero_k%0d: got v=%b r=%0d k=%h l=%b want v=1 r=%0d k=0 l=%b",
                 n, o_valid, round, Kn, o_last, n, (n == 16));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    accept_key(KEY_A, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (round !== 5'd5 || Kn !== exp_k[5]) begin
      bad++;
      $display("FAIL abort_pre: got r=%0d k=%h want r=5 k=%h", round, Kn, exp_k[5]);
    end
    // reset must win over a simultaneous load request and a frozen enable
    rst = 1'b1; enable = 1'b0; i_valid = 1'b1; key = KEY_A;
    @(posedge clk); #1;
    total++;
    if ({o_valid, o_last, busy, round, Kn} !== {3'b000, 5'd0, 48'h0}) begin
      bad++;
      $display("FAIL abort_rst: got v=%b l=%b b=%b r=%0d k=%h want 0 0 0 r=0 k=0",
               o_valid, o_last, busy, round, Kn);
    end
    rst = 1'b0; enable = 1'b1; i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_resume: got v=%b b=%b want 0 0", o_valid, busy);
    end
    accept_key(KEY_A, 1'b0);
    @(posedge clk); #1;
    total++;
    if ({o_valid, round, Kn} !== {1'b1, 5'd1, exp_k[1]}) begin
      bad++;
      $display("FAIL abort_restart: got v=%b r=%0d k=%h want v=1 r=1 k=%h",
               o_valid, round, Kn, exp_k[1]);
    end
    repeat (16) @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_k[1]  = 48'h1B02EFFC7072;
    exp_k[2]  = 48'h79AED9DBC9E5;
    exp_k[3]  = 48'h55FC8A42CF99;
    exp_k[4]  = 48'h72ADD6DB351D;
    exp_k[5]  = 48'h7CEC07EB53A8;
    exp_k[6]  = 48'h63A53E507B2F;
    exp_k[7]  = 48'hEC84B7F618BC;
    exp_k[8]  = 48'hF78A3AC13BFB;
    exp_k[9]  = 48'hE0DBEBEDE781;
    exp_k[10] = 48'hB1F347BA464F;
    exp_k[11] = 48'h215FD3DED386;
    exp_k[12] = 48'h7571F59467E9;
    exp_k[13] = 48'h97C5D1FABA41;
    exp_k[14] = 48'h5F43B7F2E73A;
    exp_k[15] = 48'hBF918D3D3F0A;
    exp_k[16] = 48'hCB3D8B0E17F5;

    test_reset;
    test_encrypt;
    test_decrypt;
    test_enable_toggle;
    test_busy_ignore;
    test_reset_abort;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
